// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES inverse SubBytes: one byte at a time, inverse affine
// followed by the GF(2^8) inverse computed as x^254 with one multiply per clock.
//
// Handshakes: a state is accepted on an edge where in_valid && in_ready;
// in_ready is high only while idle. A result is consumed on an edge where
// out_valid && out_ready; out_valid and data_out hold unchanged until then.
module inv_sub_bytes_seq #(
    parameter int NUM_BYTES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*NUM_BYTES-1:0] data_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*NUM_BYTES-1:0] data_out
);

    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BYTES - 1);
    localparam logic [3:0]       LAST_STEP = 4'd12;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EXP,
        DONE
    } state_t;

    state_t                 state;
    logic [8*NUM_BYTES-1:0] data_q;
    logic [IDX_W-1:0]       idx;
    logic [3:0]             step;
    logic [7:0]             base;
    logic [7:0]             acc;
    logic [7:0]             cur_byte;
    logic [7:0]             mul_b;
    logic [7:0]             prod;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1, shift-and-add form.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    // Inverse of the AES affine map; the constant 0x05 undoes the forward 0x63.
    function automatic logic [7:0] inv_affine(input logic [7:0] b);
        logic [7:0] a;
        logic [7:0] d;
        d = 8'h05;
        for (int i = 0; i < 8; i++) begin
            a[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8] ^ d[i];
        end
        return a;
    endfunction

    // Even steps square the accumulator, odd steps multiply by the base,
    // so after 13 steps acc = base^254 = base^-1 (and 0 stays 0).
    assign cur_byte = data_q[idx*8 +: 8];
    assign mul_b    = step[0] ? base : acc;
    assign prod     = gf_mul(acc, mul_b);

    // Control FSM with registered handshake outputs and byte-wise result writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            data_out  <= '0;
            data_q    <= '0;
            idx       <= '0;
            step      <= '0;
            base      <= '0;
            acc       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q   <= data_in;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    base  <= inv_affine(cur_byte);
                    acc   <= inv_affine(cur_byte);
                    step  <= '0;
                    state <= EXP;
                end
                EXP: begin
                    acc <= prod;
                    if (step == LAST_STEP) begin
                        data_out[idx*8 +: 8] <= prod;
                        step                 <= '0;
                        if (idx == LAST_IDX) begin
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= LOAD;
                        end
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
